bios_loader: RTL and testbench

- Boot-time reader for the BIOS ROM.
- After a start pulse it walks BIOS addresses 0..BIOS_WORDS-1, captures each 32-bit word and writes it into instruction memory at IMEM_BASE+index.
- Holds the CPU halted until the copy completes, then reports done and an XOR checksum of the copied image.
- Sits between the BIOS ROM (read port) and the instruction memory write port.

---
 rtl/bios_loader_pkg.sv | 23 ++
 rtl/bios_loader.sv | 153 +++++++++++++++
 tb/tb_bios_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bios_loader_pkg.sv
// bios_loader_pkg
//   Shared definitions for the BIOS boot loader:
//   - copy FSM state encoding
//   - default address/data widths
//   - NOP opcode words that appear in the BIOS image
package bios_loader_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;

  // NOP encodings used by the BIOS image (opaque to the loader, which copies
  // every word verbatim).
  localparam logic [31:0] BIOS_NOP_A = 32'h6C00_0000;
  localparam logic [31:0] BIOS_NOP_B = 32'h9C00_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bios_loader.sv
// bios_loader
//   Boot-time copier from the BIOS ROM into instruction memory.  After start,
//   word k of the BIOS is read at bios_address=k and written to instruction
//   memory at IMEM_BASE+k (wrapping).  The CPU is held halted until the whole
//   image is copied; an XOR checksum of the copied words is reported.
//
// Ports
//   clock_i         system clock, rising edge
//   reset_i         synchronous, active-high reset
//   start_i         level, sampled in IDLE/DONE; high begins a copy
//   bios_address_o  registered BIOS read address
//   bios_data_i     BIOS word, combinational function of bios_address_o
//   imem_address_o  registered instruction-memory write address
//   imem_data_o     registered instruction-memory write data
//   imem_we_o       one-cycle write strobe
//   busy_o          copy in progress
//   done_o          copy completed (until next start or reset)
//   cpu_halt_o      high from reset until done
//   checksum_o      XOR of all words written in the last/current copy
module bios_loader
  import bios_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BIOS_WORDS = 5,
  parameter int IMEM_BASE  = 0
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] bios_address_o,
  input  logic [DATA_WIDTH-1:0] bios_data_i,
  output logic [ADDR_WIDTH-1:0] imem_address_o,
  output logic [DATA_WIDTH-1:0] imem_data_o,
  output logic                  imem_we_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cpu_halt_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  // One extra index bit so a full 2^ADDR_WIDTH image terminates cleanly.
  localparam int                  IW        = ADDR_WIDTH + 1;
  localparam logic [IW-1:0]       LAST_IDX  = IW'(BIOS_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(IMEM_BASE);
  localparam bit                  EMPTY_IMG = (BIOS_WORDS == 0);

  state_e                  state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [ADDR_WIDTH-1:0]   bios_address_q, bios_address_d;
  logic [ADDR_WIDTH-1:0]   imem_address_q, imem_address_d;
  logic [DATA_WIDTH-1:0]   imem_data_q, imem_data_d;
  logic                    imem_we_q, imem_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cpu_halt_q, cpu_halt_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      index_q        <= '0;
      bios_address_q <= '0;
      imem_address_q <= BASE_ADDR;
      imem_data_q    <= '0;
      imem_we_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cpu_halt_q     <= 1'b1;
      checksum_q     <= '0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      bios_address_q <= bios_address_d;
      imem_address_q <= imem_address_d;
      imem_data_q    <= imem_data_d;
      imem_we_q      <= imem_we_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cpu_halt_q     <= cpu_halt_d;
      checksum_q     <= checksum_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    bios_address_d = bios_address_q;
    imem_address_d = imem_address_q;
    imem_data_d    = imem_data_q;
    imem_we_d      = 1'b0;           // strobe lasts exactly one cycle
    busy_d         = busy_q;
    done_d         = done_q;
    cpu_halt_d     = cpu_halt_q;
    checksum_d     = checksum_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          index_d        = '0;
          bios_address_d = '0;
          checksum_d     = '0;
          if (EMPTY_IMG) begin
            // Nothing to copy: complete immediately.
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cpu_halt_d = 1'b0;
          end else begin
            state_d    = ST_FETCH;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            cpu_halt_d = 1'b1;
          end
        end
      end

      // bios_address_q has been stable for a full cycle; capture the word.
      ST_FETCH: begin
        state_d        = ST_WRITE;
        imem_data_d    = bios_data_i;
        imem_address_d = BASE_ADDR + index_q[ADDR_WIDTH-1:0]; // wraps
        imem_we_d      = 1'b1;
        checksum_d     = checksum_q ^ bios_data_i;
      end

      ST_WRITE: begin
        if (index_q == LAST_IDX) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          cpu_halt_d = 1'b0;
        end else begin
          state_d        = ST_FETCH;
          index_d        = index_q + IW'(1);
          bios_address_d = index_d[ADDR_WIDTH-1:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bios_address_o = bios_address_q;
  assign imem_address_o = imem_address_q;
  assign imem_data_o    = imem_data_q;
  assign imem_we_o      = imem_we_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign cpu_halt_o     = cpu_halt_q;
  assign checksum_o     = checksum_q;

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader
//   Scoreboard bench for bios_loader.  Three instances cover a 2-word copy at
//   base 0 (A), an empty image (B) and a 2-word copy at base 1023 (C).
//   Expected instruction-memory writes (address, data, cycle) are queued when
//   a start is issued; a negedge monitor pops and compares on each strobe.
module tb_bios_loader;
  import bios_loader_pkg::*;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst;
  logic start_a, start_b, start_c;
  logic [9:0]  baddr_a, baddr_b, baddr_c;
  logic [31:0] bdata_a, bdata_b, bdata_c;
  logic [9:0]  iaddr_a, iaddr_b, iaddr_c;
  logic [31:0] idata_a, idata_b, idata_c;
  logic we_a, we_b, we_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic halt_a, halt_b, halt_c;
  logic [31:0] csum_a, csum_b, csum_c;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t q_c[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ROM models
  assign bdata_a = (baddr_a == 10'd0) ? BIOS_NOP_A : (baddr_a == 10'd1) ? BIOS_NOP_B : 32'h0;
  assign bdata_b = 32'hA5A5_A5A5;
  assign bdata_c = (baddr_c == 10'd0) ? 32'h1234_5678 : (baddr_c == 10'd1) ? 32'hDEAD_BEEF : 32'h0;

  bios_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BIOS_WORDS(2), .IMEM_BASE(0)) u_a (
    .clock_i(clk), .reset_i(rst), .start_i(start_a),
    .bios_address_o(baddr_a), .bios_data_i(bdata_a),
    .imem_address_o(iaddr_a), .imem_data_o(idata_a), .imem_we_o(we_a),
    .busy_o(busy_a), .done_o(done_a), .cpu_halt_o(halt_a), .checksum_o(csum_a));

  bios_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BIOS_WORDS(0), .IMEM_BASE(0)) u_b (
    .clock_i(clk), .reset_i(rst), .start_i(start_b),
    .bios_address_o(baddr_b), .bios_data_i(bdata_b),
    .imem_address_o(iaddr_b), .imem_data_o(idata_b), .imem_we_o(we_b),
    .busy_o(busy_b), .done_o(done_b), .cpu_halt_o(halt_b), .checksum_o(csum_b));

  bios_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BIOS_WORDS(2), .IMEM_BASE(1023)) u_c (
    .clock_i(clk), .reset_i(rst), .start_i(start_c),
    .bios_address_o(baddr_c), .bios_data_i(bdata_c),
    .imem_address_o(iaddr_c), .imem_data_o(idata_c), .imem_we_o(we_c),
    .busy_o(busy_c), .done_o(done_c), .cpu_halt_o(halt_c), .checksum_o(csum_c));

  // Write monitor: one line per observed strobe.
  always @(negedge clk) begin
    wr_t e;
    if (we_a) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL wr_a unexpected: addr=%0d data=%h cyc=%0d required=no write", iaddr_a, idata_a, cyc);
      end else begin
        e = q_a.pop_front();
        if (iaddr_a !== e.addr || idata_a !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wr_a: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                   iaddr_a, idata_a, cyc, e.addr, e.data, e.cyc);
        end else $display("ok   wr_a addr=%0d data=%h cyc=%0d", iaddr_a, idata_a, cyc);
      end
    end
    if (we_b) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL wr_b unexpected: addr=%0d data=%h cyc=%0d required=no write", iaddr_b, idata_b, cyc);
      end else begin
        e = q_b.pop_front();
        if (iaddr_b !== e.addr || idata_b !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wr_b: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                   iaddr_b, idata_b, cyc, e.addr, e.data, e.cyc);
        end else $display("ok   wr_b addr=%0d data=%h cyc=%0d", iaddr_b, idata_b, cyc);
      end
    end
    if (we_c) begin
      total++;
      if (q_c.size() == 0) begin
        bad++;
        $display("FAIL wr_c unexpected: addr=%0d data=%h cyc=%0d required=no write", iaddr_c, idata_c, cyc);
      end else begin
        e = q_c.pop_front();
        if (iaddr_c !== e.addr || idata_c !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wr_c: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                   iaddr_c, idata_c, cyc, e.addr, e.data, e.cyc);
        end else $display("ok   wr_c addr=%0d data=%h cyc=%0d", iaddr_c, idata_c, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else $display("ok   %s = %h", name, act);
  endtask

  // Full copy on instance A, entered at a negedge; leaves at the negedge after E4.
  task automatic copy_a(input bit hold);
    start_a = 1'b1;
    q_a.push_back('{addr: 10'd0, data: BIOS_NOP_A, cyc: cyc + 2});
    q_a.push_back('{addr: 10'd1, data: BIOS_NOP_B, cyc: cyc + 4});
    @(negedge clk);                       // after E0
    if (!hold) start_a = 1'b0;
    chk("a_busy_e0", 32'(busy_a), 32'd1);
    chk("a_done_e0", 32'(done_a), 32'd0);
    chk("a_halt_e0", 32'(halt_a), 32'd1);
    chk("a_csum_e0", csum_a, 32'h0);
    repeat (3) @(negedge clk);            // after E3
    chk("a_done_e3", 32'(done_a), 32'd0);
    chk("a_busy_e3", 32'(busy_a), 32'd1);
    @(negedge clk);                       // after E4
    start_a = 1'b0;
    chk("a_done_e4", 32'(done_a), 32'd1);
    chk("a_halt_e4", 32'(halt_a), 32'd0);
    chk("a_busy_e4", 32'(busy_a), 32'd0);
    chk("a_csum_e4", csum_a, 32'hF000_0000);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_baddr", 32'(baddr_a), 32'd0);
    chk("rst_iaddr", 32'(iaddr_a), 32'd0);
    chk("rst_idata", idata_a, 32'h0);
    chk("rst_we",    32'(we_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_halt",  32'(halt_a), 32'd1);
    chk("rst_csum",  csum_a, 32'h0);
    chk("rst_c_iaddr", 32'(iaddr_c), 32'd1023);
    chk("rst_b_done",  32'(done_b), 32'd0);
    rst = 1'b0;

    // Basic 2-word copy
    copy_a(1'b0);

    // Reset at E3 aborts: only word 0 gets written
    @(negedge clk);
    start_a = 1'b1;
    q_a.push_back('{addr: 10'd0, data: BIOS_NOP_A, cyc: cyc + 2});
    @(negedge clk); start_a = 1'b0;       // after E0
    @(negedge clk);                       // after E1 (word 0 strobe)
    @(negedge clk); rst = 1'b1;           // after E2; reset sampled at E3
    @(negedge clk); rst = 1'b0;           // after E3
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_halt", 32'(halt_a), 32'd1);
    chk("abort_we",   32'(we_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    @(negedge clk);                       // after E4: no strobe
    chk("abort_we_e4", 32'(we_a), 32'd0);
    copy_a(1'b0);                         // recopy after abort

    // Start held high through the whole copy: single copy only
    @(negedge clk);
    copy_a(1'b1);
    repeat (4) @(negedge clk);
    chk("hold_done", 32'(done_a), 32'd1);
    chk("hold_busy", 32'(busy_a), 32'd0);
    chk("hold_csum", csum_a, 32'hF000_0000);
    // Second start from DONE: clears done, checksum restarts from 0
    copy_a(1'b0);

    // Empty image
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_halt", 32'(halt_b), 32'd0);
    chk("b_busy", 32'(busy_b), 32'd0);
    chk("b_csum", csum_b, 32'h0);
    repeat (4) @(negedge clk);
    chk("b_done_hold", 32'(done_b), 32'd1);

    // Destination wrap at base 1023
    start_c = 1'b1;
    q_c.push_back('{addr: 10'd1023, data: 32'h1234_5678, cyc: cyc + 2});
    q_c.push_back('{addr: 10'd0,    data: 32'hDEAD_BEEF, cyc: cyc + 4});
    @(negedge clk); start_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("c_done_e3", 32'(done_c), 32'd0);
    @(negedge clk);
    chk("c_done_e4", 32'(done_c), 32'd1);
    chk("c_csum",    csum_c, 32'hCC99_E897);

    repeat (3) @(negedge clk);
    chk("q_a_empty", 32'(q_a.size()), 32'd0);
    chk("q_b_empty", 32'(q_b.size()), 32'd0);
    chk("q_c_empty", 32'(q_c.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
